sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter SRAM_AW, default 18: SRAM word-address width; sram_addr width; word index taken from addr[SRAM_AW:2].
REQ-002 Reset is rst, asynchronous, active-high; clock is clk.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0  input  1  data-port (MEM stage) request, level, held until rdy0.
REQ-006 we0  input  1  data-port write (1) / read (0), valid with req0.
REQ-007 addr0  input  32  data-port byte address; bits [1:0] and above SRAM_AW ignored.
REQ-008 wdata0  input  32  data-port store value, valid with req0 & we0.
REQ-009 rdy0  output  1  one-cycle completion pulse for data port.
REQ-010 req1  input  1  fetch-port request, read-only, level, held until rdy1.
REQ-011 addr1  input  32  fetch-port byte address, same bit use as addr0.
REQ-012 rdy1  output  1  one-cycle completion pulse for fetch port.
REQ-013 rdata  output  32  read word, valid in the rdy0/rdy1 cycle of a read, held until the next read completes.
REQ-014 sram_dq  inout  16  SRAM data bus; sram_addr output SRAM_AW; sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n outputs 1 each.

Function
REQ-015 FSM states IDLE, LO, HI, DONE; transitions IDLE->LO on accepted request, LO->HI, HI->DONE, DONE->IDLE, unconditional outside IDLE.
REQ-016 In IDLE: req0 only -> grant port 0; req1 only -> grant port 1; both -> grant port other than last_grant; none -> stay IDLE.
REQ-017 On grant edge: latch port id, word index, we (forced 0 for port 1), wdata; update last_grant.
REQ-018 LO: sram_addr = {index[SRAM_AW-2:0],0}; HI: sram_addr = {index[SRAM_AW-2:0],1}; IDLE/DONE: sram_addr = 0.
REQ-019 Write: sram_dq driven with wdata[15:0] in LO and wdata[31:16] in HI, sram_we_n = 0 in LO/HI only; sram_dq high-Z in every other state and for reads.
REQ-020 Read: sram_dq sampled into rdata[15:0] at LO->HI edge, rdata[31:16] at HI->DONE edge; sram_oe_n = 0 except during write LO/HI (1).
REQ-021 sram_ce_n, sram_ub_n, sram_lb_n constantly 0 (full 16-bit lanes).
REQ-022 DONE: rdy of granted port = 1 (registered), other rdy = 0; rdy never asserted in IDLE/LO/HI.
REQ-023 Latency: acceptance edge to rdy high = 3 cycles; back-to-back throughput one 32-bit access per 4 cycles.
REQ-024 Requester updates req/addr on the edge where its rdy is 1; request seen in the following IDLE is new.
REQ-025 Request changes while not in IDLE are ignored; latched values govern the access.
REQ-026 Both requesting continuously -> strict alternation 0,1,0,1; no port starves beyond one access.

Reset
REQ-027 rst, including mid-access, forces IDLE immediately: rdy0 = rdy1 = 0, rdata = 0, sram_we_n = 1, sram_dq high-Z, sram_addr = 0, last_grant = 1 (port 0 wins first tie); aborted access never signals rdy.

Structure
REQ-028 Shared package holds the state enum (IDLE, LO, HI, DONE), port-id constants (PORT_D = 0, PORT_I = 1) and SRAM_AW default.
REQ-029 One sub-module, sram_rr_arb2: combinational 2-way round-robin pick from req0, req1, last_grant; everything else in sram_arbiter.

Verification
REQ-030 req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF -> sram_addr 0x8 with dq 0xBEEF, then 0x9 with dq 0xDEAD, we_n low both cycles, rdy0 on 3rd cycle after acceptance.
REQ-031 Read back addr0=0x10 from SRAM model -> rdata = 0xDEADBEEF with rdy0, dq never driven by DUT.
REQ-032 req0 and req1 raised same cycle, held -> grants 0,1,0,1; rdy0/rdy1 alternate every 4 cycles.
REQ-033 req1=1 addr1=0x4 with addr0 change mid-access -> access completes on word 1 only; rdy1 only.
REQ-034 rst asserted during HI of a write -> next cycle IDLE, we_n=1, dq Z, no rdy; post-reset tie grants port 0.
REQ-035 addr0=0xFFFF_FFFE read -> bits [1:0] and above bit 18 ignored, sram_addr 0x3FFFE then 0x3FFFF.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int SRAM_AW_DEFAULT = 18;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } arbState_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time wins.
module sram_rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic lastGrant,
  output logic grantValid,
  output logic grantPort
);

  always_comb begin
    grantValid = req0 | req1;
    grantPort  = PORT_D;
    if (req0 && req1) begin
      grantPort = ~lastGrant;
    end else if (req1) begin
      grantPort = PORT_I;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a data port and a fetch port onto a 16-bit asynchronous SRAM,
// splitting each 32-bit access into a low and a high half-word cycle.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               we0,
  input  logic [31:0]        addr0,
  input  logic [31:0]        wdata0,
  output logic               rdy0,
  input  logic               req1,
  input  logic [31:0]        addr1,
  output logic               rdy1,
  output logic [31:0]        rdata,
  inout  wire  [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int IW = SRAM_AW - 1;

  arbState_t       state;
  arbState_t       nextState;
  logic            lastGrant;
  logic            grantValid;
  logic            grantPort;
  logic            portQ;
  logic            weQ;
  logic [IW-1:0]   idxQ;
  logic [31:0]     wdataQ;
  logic            dqOe;
  logic [15:0]     dqOut;
  logic            accept;
  logic            unusedAddrBits;

  // Byte-lane bits and anything above the SRAM word range are don't-care.
  assign unusedAddrBits = ^{addr0[31:SRAM_AW+1], addr0[1:0],
                            addr1[31:SRAM_AW+1], addr1[1:0]};

  sram_rr_arb2 uArb (
    .req0       (req0),
    .req1       (req1),
    .lastGrant  (lastGrant),
    .grantValid (grantValid),
    .grantPort  (grantPort)
  );

  assign accept = (state == IDLE) && grantValid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (grantValid) nextState = LO;
      LO:      nextState = HI;
      HI:      nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture at the grant edge; later request changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= PORT_I;
      portQ     <= PORT_D;
      weQ       <= 1'b0;
      idxQ      <= '0;
      wdataQ    <= '0;
    end else if (accept) begin
      lastGrant <= grantPort;
      portQ     <= grantPort;
      if (grantPort == PORT_D) begin
        weQ    <= we0;
        idxQ   <= addr0[SRAM_AW:2];
        wdataQ <= wdata0;
      end else begin
        weQ    <= 1'b0;
        idxQ   <= addr1[SRAM_AW:2];
        wdataQ <= '0;
      end
    end
  end

  // Completion pulse lands in DONE; read half-words captured as each cycle ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy0  <= 1'b0;
      rdy1  <= 1'b0;
      rdata <= '0;
    end else begin
      rdy0 <= (nextState == DONE) && (portQ == PORT_D);
      rdy1 <= (nextState == DONE) && (portQ == PORT_I);
      if (!weQ && state == LO) rdata[15:0]  <= sram_dq;
      if (!weQ && state == HI) rdata[31:16] <= sram_dq;
    end
  end

  // SRAM pin outputs
  always_comb begin
    sram_addr = '0;
    dqOe      = 1'b0;
    dqOut     = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b0;
    unique case (state)
      LO: begin
        sram_addr = {idxQ, 1'b0};
        dqOut     = wdataQ[15:0];
      end
      HI: begin
        sram_addr = {idxQ, 1'b1};
        dqOut     = wdataQ[31:16];
      end
      default: ;
    endcase
    if (weQ && (state == LO || state == HI)) begin
      dqOe      = 1'b1;
      sram_we_n = 1'b0;
      sram_oe_n = 1'b1;
    end
  end

  assign sram_dq   = dqOe ? dqOut : 'z;
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 16-bit SRAM model.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        rdy0;
  logic        req1;
  logic [31:0] addr1;
  logic        rdy1;
  logic [31:0] rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  logic        modelEn;
  logic [15:0] mem [0:(1<<18)-1];

  int checks;
  int fails;

  sram_arbiter #(.SRAM_AW(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .rdy0      (rdy0),
    .req1      (req1),
    .addr1     (addr1),
    .rdy1      (rdy1),
    .rdata     (rdata),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives on read enable, stores on the write-cycle edge.
  assign sram_dq = (modelEn && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 'z;
  always @(posedge clk) begin
    if (!sram_we_n && !sram_ce_n) mem[sram_addr] <= sram_dq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; req1 = 0; addr1 = '0;
    modelEn = 1'b0;
    tick(); tick();
    checks++; if ({rdy0, rdy1} !== 2'b00) begin fails++; $display("FAIL reset_rdy: got %b expected 00", {rdy0, rdy1}); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if (sram_we_n !== 1'b1) begin fails++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
    checks++; if (sram_addr !== 18'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
    checks++; if ({sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n} !== 4'b0000) begin fails++; $display("FAIL reset_ctl: got %b expected 0000", {sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n}); end
    rst = 1'b0;
    tick(); tick();
    checks++; if ({rdy0, rdy1, sram_addr} !== 20'h0) begin fails++; $display("FAIL idle_noreq: got %h expected 0", {rdy0, rdy1, sram_addr}); end
  endtask

  task automatic test_write();
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    tick();
    checks++; if ({sram_addr, sram_dq, sram_we_n, sram_oe_n, rdy0} !== {18'h8, 16'hBEEF, 3'b010}) begin fails++; $display("FAIL write_lo: got addr=%h dq=%h we_n=%b oe_n=%b rdy0=%b expected 8 BEEF 0 1 0", sram_addr, sram_dq, sram_we_n, sram_oe_n, rdy0); end
    tick();
    checks++; if ({sram_addr, sram_dq, sram_we_n, rdy0} !== {18'h9, 16'hDEAD, 2'b00}) begin fails++; $display("FAIL write_hi: got addr=%h dq=%h we_n=%b rdy0=%b expected 9 DEAD 0 0", sram_addr, sram_dq, sram_we_n, rdy0); end
    tick();
    checks++; if ({rdy0, rdy1, sram_we_n, sram_addr} !== {3'b101, 18'h0}) begin fails++; $display("FAIL write_done: got rdy0=%b rdy1=%b we_n=%b addr=%h expected 1 0 1 0", rdy0, rdy1, sram_we_n, sram_addr); end
    req0 = 0; we0 = 0;
    tick();
    checks++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL write_rdy_pulse: got %b expected 0", rdy0); end
    checks++; if ({mem[8], mem[9]} !== 32'hBEEFDEAD) begin fails++; $display("FAIL write_mem: got %h expected BEEFDEAD", {mem[8], mem[9]}); end
  endtask

  task automatic test_read();
    modelEn = 1;
    req0 = 1; we0 = 0; addr0 = 32'h10;
    tick();
    checks++; if ({sram_addr, sram_we_n, sram_oe_n} !== {18'h8, 2'b10}) begin fails++; $display("FAIL read_lo: got addr=%h we_n=%b oe_n=%b expected 8 1 0", sram_addr, sram_we_n, sram_oe_n); end
    tick();
    checks++; if ({sram_addr, sram_we_n} !== {18'h9, 1'b1}) begin fails++; $display("FAIL read_hi: got addr=%h we_n=%b expected 9 1", sram_addr, sram_we_n); end
    tick();
    checks++; if ({rdy0, rdy1, rdata} !== {2'b10, 32'hDEADBEEF}) begin fails++; $display("FAIL read_done: got rdy0=%b rdy1=%b rdata=%h expected 1 0 DEADBEEF", rdy0, rdy1, rdata); end
    req0 = 0;
    tick();
    checks++; if ({rdy0, rdata} !== {1'b0, 32'hDEADBEEF}) begin fails++; $display("FAIL read_hold: got rdy0=%b rdata=%h expected 0 DEADBEEF", rdy0, rdata); end
  endtask

  task automatic test_fetch_latch();
    mem[2] = 16'h5678; mem[3] = 16'h1234;
    mem[18'h20] = 16'hBBBB; mem[18'h21] = 16'hAAAA;
    req1 = 1; addr1 = 32'h4;
    tick();
    checks++; if (sram_addr !== 18'h2) begin fails++; $display("FAIL fetch_lo: got addr=%h expected 2", sram_addr); end
    req0 = 1; we0 = 0; addr0 = 32'h40; addr1 = 32'h80;
    tick();
    checks++; if ({sram_addr, rdy0, rdy1} !== {18'h3, 2'b00}) begin fails++; $display("FAIL fetch_hi: got addr=%h rdy0=%b rdy1=%b expected 3 0 0", sram_addr, rdy0, rdy1); end
    tick();
    checks++; if ({rdy0, rdy1, rdata} !== {2'b01, 32'h12345678}) begin fails++; $display("FAIL fetch_done: got rdy0=%b rdy1=%b rdata=%h expected 0 1 12345678", rdy0, rdy1, rdata); end
    req1 = 0; addr1 = 32'h4;
    tick();
    tick();
    checks++; if (sram_addr !== 18'h20) begin fails++; $display("FAIL late_req0_lo: got addr=%h expected 20", sram_addr); end
    tick(); tick();
    checks++; if ({rdy0, rdy1, rdata} !== {2'b10, 32'hAAAABBBB}) begin fails++; $display("FAIL late_req0_done: got rdy0=%b rdy1=%b rdata=%h expected 1 0 AAAABBBB", rdy0, rdy1, rdata); end
    req0 = 0;
    tick();
  endtask

  task automatic test_reset_mid_and_tie();
    logic [1:0] expRdy;
    modelEn = 0;
    req0 = 1; we0 = 1; addr0 = 32'h100; wdata0 = 32'h11112222;
    tick(); tick();
    checks++; if ({sram_addr, sram_we_n} !== {18'h81, 1'b0}) begin fails++; $display("FAIL abort_hi: got addr=%h we_n=%b expected 81 0", sram_addr, sram_we_n); end
    rst = 1;
    #1;
    checks++; if ({sram_we_n, sram_addr, rdy0, rdy1, rdata} !== {1'b1, 18'h0, 2'b00, 32'h0}) begin fails++; $display("FAIL abort_async: got we_n=%b addr=%h rdy=%b%b rdata=%h expected 1 0 00 0", sram_we_n, sram_addr, rdy0, rdy1, rdata); end
    req0 = 0; we0 = 0;
    tick();
    rst = 0;
    tick();
    checks++; if ({rdy0, rdy1, sram_we_n} !== 3'b001) begin fails++; $display("FAIL abort_no_rdy: got %b expected 001", {rdy0, rdy1, sram_we_n}); end
    modelEn = 1;
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h4;
    for (int k = 1; k <= 16; k++) begin
      tick();
      expRdy = 2'b00;
      if (k == 3 || k == 11) expRdy = 2'b10;
      if (k == 7 || k == 15) expRdy = 2'b01;
      checks++; if ({rdy0, rdy1} !== expRdy) begin fails++; $display("FAIL tie_rdy cycle %0d: got %b expected %b", k, {rdy0, rdy1}, expRdy); end
      if (expRdy == 2'b10) begin
        checks++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL tie_rdata0 cycle %0d: got %h expected DEADBEEF", k, rdata); end
      end
      if (expRdy == 2'b01) begin
        checks++; if (rdata !== 32'h12345678) begin fails++; $display("FAIL tie_rdata1 cycle %0d: got %h expected 12345678", k, rdata); end
      end
      if (k == 15) begin req0 = 0; req1 = 0; end
    end
    tick();
  endtask

  task automatic test_boundary();
    mem[18'h3FFFE] = 16'hCAFE; mem[18'h3FFFF] = 16'hF00D;
    req0 = 1; we0 = 0; addr0 = 32'hFFFF_FFFE;
    tick();
    checks++; if (sram_addr !== 18'h3FFFE) begin fails++; $display("FAIL bound_lo: got addr=%h expected 3FFFE", sram_addr); end
    tick();
    checks++; if (sram_addr !== 18'h3FFFF) begin fails++; $display("FAIL bound_hi: got addr=%h expected 3FFFF", sram_addr); end
    tick();
    checks++; if ({rdy0, rdata} !== {1'b1, 32'hF00DCAFE}) begin fails++; $display("FAIL bound_done: got rdy0=%b rdata=%h expected 1 F00DCAFE", rdy0, rdata); end
    req0 = 0;
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_write();
    test_read();
    test_fetch_latch();
    test_reset_mid_and_tie();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
